cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers results from NUM_SRC producers in small per-source FIFOs
// and broadcasts up to two of them per cycle, round-robin, on two registered CDB ports.
module cdb_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_W      = 4,
    parameter int DATA_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      has_misbranch,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*ROB_W-1:0]  src_robnum,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic                      has_rd_ready_1,
    output logic [ROB_W-1:0]          ready_robnum_1,
    output logic [DATA_W-1:0]         ready_data_1,
    output logic                      has_rd_ready_2,
    output logic [ROB_W-1:0]          ready_robnum_2,
    output logic [DATA_W-1:0]         ready_data_2
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef logic [ROB_W+DATA_W-1:0] entry_t;

    entry_t           mem   [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0] head  [NUM_SRC];
    logic [PTR_W-1:0] tail  [NUM_SRC];
    logic [CNT_W-1:0] count [NUM_SRC];
    logic [RR_W-1:0]  rr_ptr;

    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               g1_v, g2_v;
    logic [RR_W-1:0]    g1_idx, g2_idx;
    logic [RR_W-1:0]    scan_idx;
    logic [RR_W-1:0]    last_grant;
    logic [RR_W-1:0]    rr_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Readiness looks only at the registered count, so a full FIFO refuses even while popping.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            src_ready[s] = rdy && (count[s] < CNT_W'(FIFO_DEPTH));
            push[s]      = src_ready[s] && src_valid[s] && !has_misbranch;
        end
    end

    // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        g1_v     = 1'b0;
        g2_v     = 1'b0;
        g1_idx   = '0;
        g2_idx   = '0;
        scan_idx = '0;
        pop      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = RR_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (rdy && count[scan_idx] != '0) begin
                if (!g1_v) begin
                    g1_v   = 1'b1;
                    g1_idx = scan_idx;
                end else if (!g2_v) begin
                    g2_v   = 1'b1;
                    g2_idx = scan_idx;
                end
            end
        end
        if (g1_v) pop[g1_idx] = 1'b1;
        if (g2_v) pop[g2_idx] = 1'b1;
    end

    always_comb begin
        last_grant = g2_v ? g2_idx : g1_idx;
        rr_next    = (last_grant == RR_W'(NUM_SRC - 1)) ? '0 : last_grant + 1'b1;
    end

    // NOTE: the entry storage has no reset; counts and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (rst && push[s])
                mem[s][tail[s]] <= {src_robnum[s*ROB_W +: ROB_W], src_data[s*DATA_W +: DATA_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                head[s]  <= '0;
                tail[s]  <= '0;
                count[s] <= '0;
            end
            rr_ptr         <= '0;
            has_rd_ready_1 <= 1'b0;
            has_rd_ready_2 <= 1'b0;
            ready_robnum_1 <= '0;
            ready_data_1   <= '0;
            ready_robnum_2 <= '0;
            ready_data_2   <= '0;
        end else if (has_misbranch) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                head[s]  <= '0;
                tail[s]  <= '0;
                count[s] <= '0;
            end
            rr_ptr         <= '0;
            has_rd_ready_1 <= 1'b0;
            has_rd_ready_2 <= 1'b0;
        end else if (rdy) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (push[s]) tail[s] <= ptr_inc(tail[s]);
                if (pop[s])  head[s] <= ptr_inc(head[s]);
                count[s] <= count[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
            end
            has_rd_ready_1 <= g1_v;
            has_rd_ready_2 <= g2_v;
            if (g1_v) {ready_robnum_1, ready_data_1} <= mem[g1_idx][head[g1_idx]];
            if (g2_v) {ready_robnum_2, ready_data_2} <= mem[g2_idx][head[g2_idx]];
            if (g1_v) rr_ptr <= rr_next;
        end
    end

endmodule
